clk_edge_monitor: RTL and testbench



---
 rtl/clk_edge_monitor.sv | 171 +++++++++++++++++
 tb/tb_clk_edge_monitor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_edge_monitor.sv
// Brings a slow divided clock into the clk domain, emits rise/fall strobes,
// measures half periods and tracks lock / loss of the slow clock.
module clk_edge_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int EXP_HALF    = 4,
  parameter int TOL         = 0,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_stb,
  output logic             err_stb,
  output logic             locked,
  output logic             lost
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int LO_I   = (EXP_HALF > TOL) ? EXP_HALF - TOL : 0;
  localparam int HI_I   = EXP_HALF + TOL;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    LOCKED = 2'd1,
    LOST   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] s_q, s_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       gap_q, gap_d;
  logic [CNT_W-1:0]       hp_q, hp_d;
  logic                   meas_q, meas_d;
  logic                   err_q, err_d;
  logic                   first_q, first_d;
  logic [GOOD_W-1:0]      good_q, good_d;

  logic             s_last;
  logic             edge_rise;
  logic             edge_fall;
  logic             any_edge;
  logic [CNT_W-1:0] gap_inc;
  logic             in_tol;
  logic             do_meas;
  logic             timeout;

  // gap counts cycles since the last registered strobe, so gap+1 is the
  // strobe-to-strobe distance seen when the next edge is detected.
  always_comb begin
    s_last    = s_q[SYNC_STAGES-1];
    edge_rise = s_last & ~prev_q;
    edge_fall = ~s_last & prev_q;
    any_edge  = edge_rise | edge_fall;
    gap_inc   = (gap_q == CNT_MAX) ? CNT_MAX : gap_q + 1'b1;
    in_tol    = (int'(gap_inc) >= LO_I) && (int'(gap_inc) <= HI_I);
    do_meas   = any_edge & ~first_q;
    timeout   = ~any_edge && (gap_inc == TIMEOUT_C) && (state_q != LOST);
  end

  always_comb begin
    s_d    = {s_q[SYNC_STAGES-2:0], clk_in};
    prev_d = s_last;
    rise_d = edge_rise;
    fall_d = edge_fall;
    gap_d  = any_edge ? '0 : gap_inc;
    hp_d   = do_meas ? gap_inc : hp_q;
    meas_d = do_meas;
    err_d  = do_meas & ~in_tol;

    first_d = first_q;
    if (any_edge) begin
      first_d = 1'b0;
    end else if (timeout) begin
      first_d = 1'b1;
    end

    good_d = good_q;
    if (timeout) begin
      good_d = '0;
    end else if (do_meas) begin
      if (!in_tol) begin
        good_d = '0;
      end else if (good_q != GOOD_MAX) begin
        good_d = good_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      gap_q   <= '0;
      hp_q    <= '0;
      meas_q  <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b1;
      good_q  <= '0;
    end else begin
      s_q     <= s_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      gap_q   <= gap_d;
      hp_q    <= hp_d;
      meas_q  <= meas_d;
      err_q   <= err_d;
      first_q <= first_d;
      good_q  <= good_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACQ;
    end else begin
      state_q <= state_d;
    end
  end

  // An edge always beats the timeout; timeout is already masked by any_edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACQ: begin
        if (timeout) begin
          state_d = LOST;
        end else if (do_meas && in_tol && (good_d == GOOD_MAX)) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (timeout) begin
          state_d = LOST;
        end else if (do_meas && !in_tol) begin
          state_d = ACQ;
        end
      end
      LOST: begin
        if (any_edge) begin
          state_d = ACQ;
        end
      end
      default: state_d = ACQ;
    endcase
  end

  always_comb begin
    rise_stb    = rise_q;
    fall_stb    = fall_q;
    half_period = hp_q;
    meas_stb    = meas_q;
    err_stb     = err_q;
    locked      = (state_q == LOCKED);
    lost        = (state_q == LOST);
  end

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Bench for clk_edge_monitor: a default instance and a TOL=1/TIMEOUT=255
// instance, checked by directed vector tables and a timestamp-based model.
module tb_clk_edge_monitor;

  localparam int S   = 2;
  localparam int HSZ = 16384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ci0 = 1'b0;
  logic ci1 = 1'b0;

  logic       rise_o [2];
  logic       fall_o [2];
  logic       meas_o [2];
  logic       err_o  [2];
  logic       lk_o   [2];
  logic       lost_o [2];
  logic [7:0] hp_o   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_edge_monitor u0 (
    .clk(clk), .rst(rst), .clk_in(ci0),
    .rise_stb(rise_o[0]), .fall_stb(fall_o[0]), .half_period(hp_o[0]),
    .meas_stb(meas_o[0]), .err_stb(err_o[0]), .locked(lk_o[0]), .lost(lost_o[0])
  );

  clk_edge_monitor #(.TOL(1), .TIMEOUT(255)) u1 (
    .clk(clk), .rst(rst), .clk_in(ci1),
    .rise_stb(rise_o[1]), .fall_stb(fall_o[1]), .half_period(hp_o[1]),
    .meas_stb(meas_o[1]), .err_stb(err_o[1]), .locked(lk_o[1]), .lost(lost_o[1])
  );

  // Reference model: timestamps of samples and strobes, per instance.
  int  tol_p [2] = '{0, 1};
  int  tmo_p [2] = '{64, 255};
  bit  hist  [2][HSZ];
  int  t_m [2], last_m [2], good_m [2], hp_m [2];
  bit  first_m [2], lk_m [2], lost_m [2];
  bit  rise_m [2], fall_m [2], meas_m [2], err_m [2];

  function automatic bit sample_at(int d, int t);
    if (t < 1 || t >= HSZ) return 1'b0;
    return hist[d][t];
  endfunction

  function automatic void model_step(int d, bit r, bit ci);
    bit a, b, ev;
    int m;
    rise_m[d] = 1'b0; fall_m[d] = 1'b0; meas_m[d] = 1'b0; err_m[d] = 1'b0;
    if (r) begin
      t_m[d] = 0; last_m[d] = 0; good_m[d] = 0; hp_m[d] = 0;
      first_m[d] = 1'b1; lk_m[d] = 1'b0; lost_m[d] = 1'b0;
      return;
    end
    t_m[d] = t_m[d] + 1;
    if (t_m[d] < HSZ) hist[d][t_m[d]] = ci;
    a  = sample_at(d, t_m[d] - S);
    b  = sample_at(d, t_m[d] - S - 1);
    ev = (a != b);
    if (ev) begin
      rise_m[d] = a;
      fall_m[d] = ~a;
      if (first_m[d]) begin
        first_m[d] = 1'b0;
        lost_m[d]  = 1'b0;
      end else begin
        m = t_m[d] - last_m[d];
        if (m > 255) m = 255;
        hp_m[d] = m;
        meas_m[d] = 1'b1;
        if (m >= 4 - tol_p[d] && m <= 4 + tol_p[d]) begin
          good_m[d] = (good_m[d] >= 4) ? 4 : good_m[d] + 1;
          if (good_m[d] == 4) lk_m[d] = 1'b1;
        end else begin
          err_m[d]  = 1'b1;
          good_m[d] = 0;
          lk_m[d]   = 1'b0;
        end
      end
      last_m[d] = t_m[d];
    end else if (!lost_m[d] && (t_m[d] - last_m[d]) == tmo_p[d]) begin
      lost_m[d]  = 1'b1;
      lk_m[d]    = 1'b0;
      first_m[d] = 1'b1;
      good_m[d]  = 0;
    end
  endfunction

  function automatic void check(string nm, int d, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%0d required=%0d", nm, d, $time, act, exp);
    end
  endfunction

  task automatic tick();
    bit r_s, c0, c1;
    @(posedge clk);
    r_s = rst; c0 = ci0; c1 = ci1;
    #1;
    model_step(0, r_s, c0);
    model_step(1, r_s, c1);
    for (int d = 0; d < 2; d++) begin
      check("model_rise",   d, rise_o[d], rise_m[d]);
      check("model_fall",   d, fall_o[d], fall_m[d]);
      check("model_meas",   d, meas_o[d], meas_m[d]);
      check("model_hp",     d, hp_o[d],   hp_m[d]);
      check("model_err",    d, err_o[d],  err_m[d]);
      check("model_locked", d, lk_o[d],   lk_m[d]);
      check("model_lost",   d, lost_o[d], lost_m[d]);
    end
  endtask

  task automatic set_ci(int d, bit v);
    if (d == 0) ci0 = v; else ci1 = v;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  task automatic check_zero(string nm);
    for (int d = 0; d < 2; d++) begin
      check({nm, "_rise"},   d, rise_o[d], 0);
      check({nm, "_fall"},   d, fall_o[d], 0);
      check({nm, "_meas"},   d, meas_o[d], 0);
      check({nm, "_hp"},     d, hp_o[d],   0);
      check({nm, "_err"},    d, err_o[d],  0);
      check({nm, "_locked"}, d, lk_o[d],   0);
      check({nm, "_lost"},   d, lost_o[d], 0);
    end
  endtask

  typedef struct {
    int d;
    bit lvl;
    int hold;
    bit rise, fall, meas;
    int hp;
    bit err, lk, lost;
  } vec_t;

  vec_t tbl [17];

  task automatic apply_vec(int i);
    set_ci(tbl[i].d, tbl[i].lvl);
    for (int c = 0; c < tbl[i].hold; c++) begin
      tick();
      if (c == S) begin
        check("tbl_rise",   tbl[i].d, rise_o[tbl[i].d], tbl[i].rise);
        check("tbl_fall",   tbl[i].d, fall_o[tbl[i].d], tbl[i].fall);
        check("tbl_meas",   tbl[i].d, meas_o[tbl[i].d], tbl[i].meas);
        check("tbl_hp",     tbl[i].d, hp_o[tbl[i].d],   tbl[i].hp);
        check("tbl_err",    tbl[i].d, err_o[tbl[i].d],  tbl[i].err);
        check("tbl_locked", tbl[i].d, lk_o[tbl[i].d],   tbl[i].lk);
        check("tbl_lost",   tbl[i].d, lost_o[tbl[i].d], tbl[i].lost);
      end
    end
  endtask

  // Hold the input until the timeout; k0 cycles have already passed since the last strobe.
  task automatic wait_lost(int d, int tmo, int k0);
    for (int k = k0 + 1; k <= tmo; k++) begin
      tick();
      if (k == tmo - 1) check("lost_early", d, lost_o[d], 0);
      if (k == tmo) begin
        check("lost_set", d, lost_o[d], 1);
        check("lost_unlock", d, lk_o[d], 0);
      end
    end
  endtask

  function automatic int pick_hold();
    int p;
    p = $urandom_range(0, 99);
    if (p < 70) return $urandom_range(3, 5);
    if (p < 88) return $urandom_range(1, 2);
    return $urandom_range(60, 300);
  endfunction

  initial begin
    int rem [2];
    //          d lvl hold rise fall meas hp err lk lost
    tbl[0]  = '{0, 1, 4, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 4, 0, 1, 1, 4, 0, 0, 0};
    tbl[2]  = '{0, 1, 4, 1, 0, 1, 4, 0, 0, 0};
    tbl[3]  = '{0, 0, 4, 0, 1, 1, 4, 0, 0, 0};
    tbl[4]  = '{0, 1, 4, 1, 0, 1, 4, 0, 1, 0};
    tbl[5]  = '{0, 0, 4, 0, 1, 1, 4, 0, 1, 0};
    tbl[6]  = '{0, 1, 3, 1, 0, 1, 4, 0, 1, 0};
    tbl[7]  = '{0, 0, 4, 0, 1, 1, 3, 1, 0, 0};
    tbl[8]  = '{0, 1, 4, 1, 0, 1, 4, 0, 0, 0};
    tbl[9]  = '{0, 0, 4, 0, 1, 1, 4, 0, 0, 0};
    tbl[10] = '{0, 1, 4, 1, 0, 1, 4, 0, 0, 0};
    tbl[11] = '{0, 0, 4, 0, 1, 1, 4, 0, 1, 0};
    tbl[12] = '{1, 1, 5, 1, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 3, 0, 1, 1, 5, 0, 0, 0};
    tbl[14] = '{1, 1, 5, 1, 0, 1, 3, 0, 0, 0};
    tbl[15] = '{1, 0, 3, 0, 1, 1, 5, 0, 0, 0};
    tbl[16] = '{1, 1, 4, 1, 0, 1, 3, 0, 1, 0};

    do_reset(2);
    check_zero("reset");

    // Strobe latency: rise visible only at the third edge after the change.
    for (int i = 0; i < 5; i++) tick();
    ci0 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("latency_rise", 0, rise_o[0], (c == S) ? 1 : 0);
    end

    // Divide-by-8 lock, glitch out of lock, relock, then timeout.
    ci0 = 1'b0;
    do_reset(1);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i <= 11; i++) apply_vec(i);
    wait_lost(0, 64, 1);
    for (int i = 0; i < 10; i++) tick();
    ci0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == S) begin
        check("restart_rise", 0, rise_o[0], 1);
        check("restart_lost", 0, lost_o[0], 0);
        check("restart_meas", 0, meas_o[0], 0);
      end
    end
    for (int i = 1; i <= 5; i++) apply_vec(i);

    // Reset while locked, then relock from scratch.
    do_reset(1);
    check_zero("midreset");
    tick();
    for (int i = 0; i <= 4; i++) apply_vec(i);

    // Tolerance instance: 5,3,5,3 locks without errors, then a 300-cycle half period.
    do_reset(1);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 12; i <= 16; i++) apply_vec(i);
    wait_lost(1, 255, 1);
    for (int i = 0; i < 44; i++) tick();
    ci1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == S) begin
        check("tol_restart_fall", 1, fall_o[1], 1);
        check("tol_restart_lost", 1, lost_o[1], 0);
        check("tol_restart_meas", 1, meas_o[1], 0);
      end
    end

    // Randomized half periods and occasional resets, checked against the model.
    do_reset(1);
    rem[0] = pick_hold();
    rem[1] = pick_hold();
    for (int n = 0; n < 5000; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (rem[d] == 0) begin
          set_ci(d, (d == 0) ? ~ci0 : ~ci1);
          rem[d] = pick_hold();
        end
        rem[d] = rem[d] - 1;
      end
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
